// File: rtl/pwm_comparador.sv
// pwm_comparador: compares the counter against a ramped duty with glitch-free duty updates at period wrap
module pwm_comparador #(
  parameter int N       = 10,
  parameter int STEP    = 64,
  parameter int RAMP_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] z,
  input  logic         enable,
  input  logic [N-1:0] duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm,
  output logic         period_tick,
  output logic [1:0]   state,
  output logic [N-1:0] duty_act
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10} state_t;
  localparam logic [N:0]   STEP_W = (N+1)'(STEP);
  localparam logic [N-1:0] STEP_N = N'(STEP);
  state_t st, st_n;
  logic [N-1:0] target, pend_val, act_n, ramp_val, stop_val;
  logic [N:0] up_d, dn_d;
  logic bnd, acc, pending, pending_n;
  assign state = st;
  assign bnd = (z == {N{1'b1}});
  assign acc = duty_valid && duty_ready;
  assign pending_n = acc || (pending && !bnd);
  assign up_d = {1'b0, target} - {1'b0, duty_act};
  assign dn_d = {1'b0, duty_act} - {1'b0, target};
  assign ramp_val = (RAMP_EN == 0) ? target :
                    (target > duty_act) ? ((up_d > STEP_W) ? duty_act + STEP_N : target) :
                    ((dn_d > STEP_W) ? duty_act - STEP_N : target);
  assign stop_val = (RAMP_EN != 0 && {1'b0, duty_act} > STEP_W) ? duty_act - STEP_N : '0;
  // next state and next applied duty; both only move on a wrap edge
  always_comb begin
    st_n = st;
    act_n = duty_act;
    if (bnd) begin
      case (st)
        IDLE: begin
          act_n = '0;
          if (enable) begin
            st_n = RUN;
            act_n = ramp_val;
          end
        end
        RUN: begin
          if (!enable) st_n = STOP;
          else act_n = ramp_val;
        end
        STOP: begin
          if (enable) st_n = RUN;
          else begin
            act_n = stop_val;
            if (duty_act == '0) st_n = IDLE;
          end
        end
        default: begin
          st_n = IDLE;
          act_n = '0;
        end
      endcase
    end
  end
  // handshake, shadow duty, FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      duty_act    <= '0;
      target      <= '0;
      pend_val    <= '0;
      pending     <= 1'b0;
      duty_ready  <= 1'b1;
      pwm         <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      if (acc) pend_val <= duty_in;
      if (bnd && pending) target <= pend_val;
      pending     <= pending_n;
      duty_ready  <= !pending_n;
      st          <= st_n;
      duty_act    <= act_n;
      pwm         <= (st != IDLE) && (z < duty_act);
      period_tick <= bnd;
    end
  end
endmodule

// File: tb/tb_pwm_comparador.sv
// tb_pwm_comparador: directed scoreboard bench for the ramped and non-ramped comparator
module tb_pwm_comparador;
  localparam int N = 10;
  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, duty_valid = 1'b0;
  logic [N-1:0] z = '0, duty_in = '0;
  logic r1_ready, r1_pwm, r1_tick, r0_ready, r0_pwm, r0_tick;
  logic [1:0] r1_state, r0_state;
  logic [N-1:0] r1_act, r0_act;
  exp_t q[$];
  int tests = 0, fails = 0;
  int hi, ticks;
  logic p511, p512;
  int ramp_up[5]  = '{64, 128, 192, 200, 200};
  int stop_r1[5]  = '{200, 136, 72, 8, 0};
  int stop_r0a[5] = '{200, 0, 0, 0, 0};
  int stop_r0s[5] = '{2, 2, 0, 0, 0};

  always #5 clk = ~clk;
  // free-running upstream counter
  always @(posedge clk) z <= z + 1'b1;

  pwm_comparador #(.N(N), .STEP(64), .RAMP_EN(1)) dut (
    .clk(clk), .rst(rst), .z(z), .enable(enable), .duty_in(duty_in), .duty_valid(duty_valid),
    .duty_ready(r1_ready), .pwm(r1_pwm), .period_tick(r1_tick), .state(r1_state), .duty_act(r1_act)
  );
  pwm_comparador #(.N(N), .STEP(64), .RAMP_EN(0)) dut0 (
    .clk(clk), .rst(rst), .z(z), .enable(enable), .duty_in(duty_in), .duty_valid(duty_valid),
    .duty_ready(r0_ready), .pwm(r0_pwm), .period_tick(r0_tick), .state(r0_state), .duty_act(r0_act)
  );

  function automatic void push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    q.push_back(e);
  endfunction

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %0d, nothing expected", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        fails++;
        $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic wait_z(input logic [N-1:0] v);
    int n = 0;
    while (z !== v && n < 2100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2100) begin
      tests++;
      fails++;
      $error("FAIL wait_z_timeout: got z=%0d expected %0d", z, v);
    end
  endtask

  task automatic next_bnd();
    @(negedge clk);
    wait_z(10'h3ff);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    push("rst_pwm", 0); push("rst_tick", 0); push("rst_state", 0);
    push("rst_act", 0); push("rst_ready", 1); push("rst_r0_ready", 1);
    chk(32'(r1_pwm)); chk(32'(r1_tick)); chk(32'(r1_state));
    chk(32'(r1_act)); chk(32'(r1_ready)); chk(32'(r0_ready));
    rst = 1'b1;
    @(negedge clk);
    enable = 1'b1; duty_in = 10'd512; duty_valid = 1'b1;
    push("acc_ready_drop", 0); push("acc_r0_ready_drop", 0);
    @(negedge clk);
    duty_valid = 1'b0;
    chk(32'(r1_ready)); chk(32'(r0_ready));
    push("b1_r0_state", 1); push("b1_r0_act", 0); push("b1_r1_act", 0); push("b1_r0_ready", 1);
    next_bnd();
    chk(32'(r0_state)); chk(32'(r0_act)); chk(32'(r1_act)); chk(32'(r0_ready));
    push("b2_r0_act", 512); push("b2_r1_act", 64);
    next_bnd();
    chk(32'(r0_act)); chk(32'(r1_act));
    push("r0_pwm_z511", 1); push("r0_pwm_z512", 0); push("r0_high_cnt", 512); push("b3_r1_act", 128);
    hi = 0; p511 = 1'b0; p512 = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (r0_pwm) hi++;
      if (z == 10'd512) p511 = r0_pwm;
      if (z == 10'd513) p512 = r0_pwm;
    end
    chk(32'(p511)); chk(32'(p512)); chk(hi); chk(32'(r1_act));
    wait_z(10'd400);
    push("pre_rst_r0_pwm", 1);
    chk(32'(r0_pwm));
    rst = 1'b0;
    push("async_r0_pwm", 0); push("async_r0_state", 0); push("async_r0_act", 0);
    push("async_r0_ready", 1); push("async_r1_act", 0); push("async_r1_tick", 0);
    #1;
    chk(32'(r0_pwm)); chk(32'(r0_state)); chk(32'(r0_act));
    chk(32'(r0_ready)); chk(32'(r1_act)); chk(32'(r1_tick));
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push("idle_tick", 1); push("idle_state", 0);
    next_bnd();
    chk(32'(r1_tick)); chk(32'(r1_state));
    push("idle_tick_cnt", 1);
    ticks = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (r1_tick) ticks++;
    end
    chk(ticks);
    duty_in = 10'd200; duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    push("idle_load_act", 0); push("idle_load_state", 0);
    next_bnd();
    chk(32'(r1_act)); chk(32'(r1_state));
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push("ramp_up_act", ramp_up[i]); push("ramp_up_state", 1);
      next_bnd();
      chk(32'(r1_act)); chk(32'(r1_state));
    end
    push("r0_jump_act", 200); push("r0_jump_state", 1);
    chk(32'(r0_act)); chk(32'(r0_state));
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push("stop_r1_act", stop_r1[i]); push("stop_r1_state", 2);
      push("stop_r0_act", stop_r0a[i]); push("stop_r0_state", stop_r0s[i]);
      next_bnd();
      chk(32'(r1_act)); chk(32'(r1_state)); chk(32'(r0_act)); chk(32'(r0_state));
    end
    push("stop_zero_pwm_cnt", 0); push("stop_to_idle", 0);
    hi = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (r1_pwm) hi++;
    end
    chk(hi); chk(32'(r1_state));
    enable = 1'b1; duty_in = 10'd300; duty_valid = 1'b1;
    @(negedge clk);
    duty_in = 10'd700;
    push("hs_ready_low", 0);
    chk(32'(r0_ready));
    push("h1_ready", 1); push("h1_r0_act", 200); push("h1_r0_state", 1);
    next_bnd();
    chk(32'(r0_ready)); chk(32'(r0_act)); chk(32'(r0_state));
    @(negedge clk);
    duty_valid = 1'b0;
    push("h1_accept_700", 0);
    chk(32'(r0_ready));
    push("h2_r0_act", 300);
    next_bnd();
    chk(32'(r0_act));
    push("h3_r0_act", 700);
    next_bnd();
    chk(32'(r0_act));
    wait_z(10'h3ff);
    push("coin_ready_pre", 1);
    chk(32'(r0_ready));
    duty_in = 10'd100; duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    push("coin_ready_held", 0); push("h4_r0_act", 700);
    chk(32'(r0_ready)); chk(32'(r0_act));
    push("h5_r0_act", 700);
    next_bnd();
    chk(32'(r0_act));
    push("h6_r0_act", 100); push("h6_r1_down", 256);
    next_bnd();
    chk(32'(r0_act)); chk(32'(r1_act));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
